sticky_capture_bank: RTL and testbench

Multi-channel armed capture register, the parametrised successor of the single-channel sticky enable register. Each channel is armed by a one-cycle request and then captures one selected `valid_in` beat: the first, or a later beat if a skip count is given. The capture is held on `data_out` and flagged until software or the consuming logic acknowledges it. The block sits between the scheduler datapath and the control/status plane, where it snapshots queue and rank values on demand.

---
 rtl/sticky_capture_pkg.sv | 15 +
 rtl/sticky_capture_channel.sv | 104 ++++++++++
 rtl/sticky_capture_bank.sv | 51 +++++
 tb/tb_sticky_capture_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sticky_capture_pkg.sv
// Shared definitions for the sticky capture bank: FSM encodings and slice helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sticky_capture_pkg;

   // Per-channel FSM encodings, kept as plain constants for legacy tooling.
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_ARMED = 1'b1;

   // Low bit index of channel idx inside a packed CHANNELS*w bus.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/sticky_capture_channel.sv
// One armed capture channel: arm, skip n valid beats, snapshot the next, hold it until ack.
// Latency: arm -> armed 1 cycle; capturing beat -> data_out/captured/capture_pulse 1 cycle.
// Backpressure: none; valid_in beats are counted or captured only while armed, else dropped.
// Optional feature: STICKY_CAPTURE_BANK_OVERRUN_EN adds the sticky overrun flag.
module sticky_capture_channel
   import sticky_capture_pkg::*;
#(
   parameter int              WIDTH       = 8,
   parameter int              SKIP_W      = 4,
   parameter logic [WIDTH-1:0] DEFAULT_OUT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              disarm,
   input  logic [SKIP_W-1:0] skip,
   input  logic              ack,
   input  logic              valid_in,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  data_out,
   output logic              armed,
   output logic              captured,
   output logic              capture_pulse,
   output logic              overrun
);

   logic              state;
   logic [SKIP_W-1:0] cnt;
   logic              cap;

   // A capture is the armed beat that survives disarm and has no skips left.
   always_comb begin
      cap = (state == ST_ARMED) && !disarm && valid_in && (cnt == '0);
   end

   // FSM and skip counter; a capture with arm held re-arms without an idle gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm && !disarm) begin
                  state <= ST_ARMED;
                  cnt   <= skip;
               end
            end
            default: begin
               if (disarm) begin
                  state <= ST_IDLE;
               end else if (valid_in) begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else if (arm) begin
                     cnt <= skip;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
         endcase
      end
   end

   // Captured data and flags; a capture beats a simultaneous ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out      <= DEFAULT_OUT;
         captured      <= 1'b0;
         capture_pulse <= 1'b0;
      end else begin
         capture_pulse <= cap;
         if (cap) begin
            data_out <= data_in;
            captured <= 1'b1;
         end else if (ack) begin
            captured <= 1'b0;
         end
      end
   end

   assign armed = (state == ST_ARMED);

`ifdef STICKY_CAPTURE_BANK_OVERRUN_EN
   logic overrun_q;

   // Overrun marks a capture that landed on an unacknowledged one.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (cap && captured && !ack) begin
         overrun_q <= 1'b1;
      end else if (ack && !cap) begin
         overrun_q <= 1'b0;
      end
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: rtl/sticky_capture_bank.sv
// Bank of independent armed capture channels snapshotting datapath values for the control plane.
// Latency: arm -> armed 1 cycle; capturing beat -> outputs 1 cycle; all outputs registered.
// Backpressure: none; channels never stall valid_in, unarmed beats are dropped.
// Optional feature: STICKY_CAPTURE_BANK_OVERRUN_EN enables per-channel overrun flags.
module sticky_capture_bank
   import sticky_capture_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               CHANNELS    = 4,
   parameter int               SKIP_W      = 4,
   parameter logic [WIDTH-1:0] DEFAULT_OUT = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       arm,
   input  logic [CHANNELS-1:0]       disarm,
   input  logic [SKIP_W-1:0]         skip,
   input  logic [CHANNELS-1:0]       ack,
   input  logic [CHANNELS-1:0]       valid_in,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   output logic [CHANNELS*WIDTH-1:0] data_out,
   output logic [CHANNELS-1:0]       armed,
   output logic [CHANNELS-1:0]       captured,
   output logic [CHANNELS-1:0]       capture_pulse,
   output logic [CHANNELS-1:0]       overrun
);

   // One channel per slice; the top level only routes the packed buses.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      sticky_capture_channel #(
         .WIDTH       (WIDTH),
         .SKIP_W      (SKIP_W),
         .DEFAULT_OUT (DEFAULT_OUT)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .arm           (arm[i]),
         .disarm        (disarm[i]),
         .skip          (skip),
         .ack           (ack[i]),
         .valid_in      (valid_in[i]),
         .data_in       (data_in[slice_lo(i, WIDTH) +: WIDTH]),
         .data_out      (data_out[slice_lo(i, WIDTH) +: WIDTH]),
         .armed         (armed[i]),
         .captured      (captured[i]),
         .capture_pulse (capture_pulse[i]),
         .overrun       (overrun[i])
      );
   end

endmodule

// File: tb/tb_sticky_capture_bank.sv
// Directed bench for sticky_capture_bank plus a scoreboarded multi-channel stream.
// Latency: inputs applied 1 time unit after an edge, outputs checked 1 time unit after the next.
// Backpressure: n/a.
module tb_sticky_capture_bank;

   localparam int         W   = 8;
   localparam int         CH  = 4;
   localparam int         SW  = 4;
   localparam logic [7:0] DEF = 8'h3C;

`ifdef STICKY_CAPTURE_BANK_OVERRUN_EN
   localparam logic OVR_ON = 1'b1;
`else
   localparam logic OVR_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [CH-1:0]   arm, disarm, ack, valid_in;
   logic [SW-1:0]   skip;
   logic [CH*W-1:0] data_in;
   logic [CH*W-1:0] data_out;
   logic [CH-1:0]   armed, captured, capture_pulse, overrun;

   int checks   = 0;
   int failures = 0;

   // Model state for the multi-channel stream.
   logic [CH-1:0] m_armed;
   logic [CH-1:0] m_cap;
   logic [SW-1:0] m_cnt [CH];
   logic [W-1:0]  m_dat [CH];
   logic [CH*W-1:0] m_bus;

   sticky_capture_bank #(
      .WIDTH       (W),
      .CHANNELS    (CH),
      .SKIP_W      (SW),
      .DEFAULT_OUT (DEF)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .arm           (arm),
      .disarm        (disarm),
      .skip          (skip),
      .ack           (ack),
      .valid_in      (valid_in),
      .data_in       (data_in),
      .data_out      (data_out),
      .armed         (armed),
      .captured      (captured),
      .capture_pulse (capture_pulse),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      arm = '0; disarm = '0; ack = '0; valid_in = '0; skip = '0; data_in = '0;
   endtask

   function automatic logic [7:0] ch_out(input int i);
      return data_out[i*W +: W];
   endfunction

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_data",    data_out, {4{DEF}});
      check("rst_armed",   {28'd0, armed}, 32'd0);
      check("rst_capt",    {28'd0, captured}, 32'd0);
      check("rst_pulse",   {28'd0, capture_pulse}, 32'd0);
      check("rst_overrun", {28'd0, overrun}, 32'd0);

      // Valid beats while unarmed are ignored
      valid_in = 4'hF; data_in = {4{8'hAA}};
      tick();
      idle_inputs();
      tick();
      check("unarmed_data", data_out, {4{DEF}});
      check("unarmed_capt", {28'd0, captured}, 32'd0);

      // Basic capture on ch0, skip 0
      arm = 4'b0001;
      tick();
      idle_inputs();
      check("basic_armed", {31'd0, armed[0]}, 32'd1);
      valid_in = 4'b0001; data_in[7:0] = 8'h5A;
      tick();
      idle_inputs();
      check("basic_data",  {24'd0, ch_out(0)}, 32'h5A);
      check("basic_capt",  {31'd0, captured[0]}, 32'd1);
      check("basic_pulse", {28'd0, capture_pulse}, 32'h1);
      check("basic_disarmed", {31'd0, armed[0]}, 32'd0);
      tick();
      check("basic_pulse_gone", {28'd0, capture_pulse}, 32'h0);
      check("basic_hold", {24'd0, ch_out(0)}, 32'h5A);
      ack = 4'b0001;
      tick();
      idle_inputs();
      check("basic_ack", {31'd0, captured[0]}, 32'd0);
      check("basic_ack_hold", {24'd0, ch_out(0)}, 32'h5A);

      // Skip 2 on ch1; the beat coinciding with arm must not count
      arm = 4'b0010; skip = 4'd2; valid_in = 4'b0010; data_in[15:8] = 8'hEE;
      tick();
      idle_inputs();
      check("skip_armed", {31'd0, armed[1]}, 32'd1);
      valid_in = 4'b0010; data_in[15:8] = 8'h01;
      tick();
      data_in[15:8] = 8'h02;
      tick();
      check("skip_still_armed", {31'd0, armed[1]}, 32'd1);
      check("skip_no_capt_yet", {31'd0, captured[1]}, 32'd0);
      data_in[15:8] = 8'h03;
      tick();
      idle_inputs();
      check("skip_data", {24'd0, ch_out(1)}, 32'h03);
      check("skip_capt", {31'd0, captured[1]}, 32'd1);
      check("skip_idle", {31'd0, armed[1]}, 32'd0);

      // Disarm beats a simultaneous valid on ch2
      arm = 4'b0100;
      tick();
      idle_inputs();
      disarm = 4'b0100; valid_in = 4'b0100; data_in[23:16] = 8'hFF;
      tick();
      idle_inputs();
      check("disarm_data",  {24'd0, ch_out(2)}, {24'd0, DEF});
      check("disarm_armed", {31'd0, armed[2]}, 32'd0);
      check("disarm_capt",  {31'd0, captured[2]}, 32'd0);
      arm = 4'b0100; disarm = 4'b0100;
      tick();
      idle_inputs();
      check("arm_disarm_idle", {31'd0, armed[2]}, 32'd0);

      // Back-to-back re-arm on ch3, second capture without ack
      arm = 4'b1000;
      tick();
      arm = 4'b1000; valid_in = 4'b1000; data_in[31:24] = 8'h11;
      tick();
      idle_inputs();
      check("rearm_data1", {24'd0, ch_out(3)}, 32'h11);
      check("rearm_armed", {31'd0, armed[3]}, 32'd1);
      check("rearm_pulse1", {28'd0, capture_pulse}, 32'h8);
      valid_in = 4'b1000; data_in[31:24] = 8'h22;
      tick();
      idle_inputs();
      check("rearm_data2", {24'd0, ch_out(3)}, 32'h22);
      check("rearm_capt2", {31'd0, captured[3]}, 32'd1);
      check("rearm_overrun", {31'd0, overrun[3]}, {31'd0, OVR_ON});
      check("rearm_idle", {31'd0, armed[3]}, 32'd0);
      ack = 4'b1000;
      tick();
      idle_inputs();
      check("ack_clr_capt", {31'd0, captured[3]}, 32'd0);
      check("ack_clr_ovr",  {31'd0, overrun[3]}, 32'd0);

      // Ack and capture in the same cycle: capture wins
      arm = 4'b1000;
      tick();
      idle_inputs();
      ack = 4'b1000; valid_in = 4'b1000; data_in[31:24] = 8'h33;
      tick();
      idle_inputs();
      check("ack_vs_cap_capt", {31'd0, captured[3]}, 32'd1);
      check("ack_vs_cap_data", {24'd0, ch_out(3)}, 32'h33);
      check("ack_vs_cap_ovr",  {31'd0, overrun[3]}, 32'd0);

      // Reset with a capture pending drops it and restores defaults
      arm = 4'b0001;
      tick();
      idle_inputs();
      rst = 1'b1; valid_in = 4'b0001; data_in[7:0] = 8'h77;
      tick();
      rst = 1'b0;
      idle_inputs();
      check("midrst_data",  data_out, {4{DEF}});
      check("midrst_armed", {28'd0, armed}, 32'd0);
      check("midrst_capt",  {28'd0, captured}, 32'd0);
      check("midrst_pulse", {28'd0, capture_pulse}, 32'd0);

      // Independence: stagger arms with distinct skips, random valid/data streams
      m_armed = '0;
      m_cap   = '0;
      for (int i = 0; i < CH; i++) begin
         m_cnt[i] = '0;
         m_dat[i] = DEF;
      end
      for (int c = 0; c < 48; c++) begin
         arm      = (c < CH) ? (4'b0001 << c) : 4'b0000;
         skip     = (c < CH) ? SW'(c) : SW'(0);
         valid_in = CH'($urandom);
         data_in  = $urandom;
         for (int i = 0; i < CH; i++) begin
            if (!m_armed[i]) begin
               if (arm[i]) begin
                  m_armed[i] = 1'b1;
                  m_cnt[i]   = skip;
               end
            end else if (valid_in[i]) begin
               if (m_cnt[i] == '0) begin
                  m_dat[i]   = data_in[i*W +: W];
                  m_cap[i]   = 1'b1;
                  m_armed[i] = 1'b0;
               end else begin
                  m_cnt[i] = m_cnt[i] - 1'b1;
               end
            end
         end
         tick();
         check($sformatf("indep_armed_c%0d", c), {28'd0, armed}, {28'd0, m_armed});
      end
      idle_inputs();
      for (int i = 0; i < CH; i++) m_bus[i*W +: W] = m_dat[i];
      check("indep_data", data_out, m_bus);
      check("indep_capt", {28'd0, captured}, {28'd0, m_cap});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
